// File: rtl/fetch_stage_if.sv
// Instruction-memory channel of the fetch stage: a valid/ready request path
// and an in-order, non-backpressured response path.
interface fetch_stage_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: issues sequential fetches under a credit limit,
// queues returned words with their PC, drops words made stale by a redirect,
// and presents one instruction per cycle to the IF/ID register.
//
// state  | meaning
// -------+-------------------------------------------------------------
// RUN    | every returning word belongs to the current fetch stream
// DRAIN  | discard > 0: returning words predate a redirect and are dropped
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INSN = 16'h0000,
    parameter int          QDEPTH   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 jump,
    input  logic [15:0]          new_pc,
    fetch_stage_if.master        imem,
    output logic [15:0]          pc_out,
    output logic [15:0]          pcp2_out,
    output logic [15:0]          ir_out,
    output logic                 fetch_valid
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);
    // Outstanding-request counters; a redirect storm can stack stale
    // requests beyond QDEPTH, so these are wider and saturate.
    localparam int NW = 8;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic           drop_stale;

    logic [15:0]    fetch_pc_q, fetch_pc_d;
    logic [15:0]    rsp_pc_q, rsp_pc_d;
    logic [NW-1:0]  inflight_q, inflight_d;
    logic [NW-1:0]  discard_q, discard_d;

    logic [15:0]    q_pc_q [QDEPTH];
    logic [15:0]    q_pc_d [QDEPTH];
    logic [15:0]    q_ir_q [QDEPTH];
    logic [15:0]    q_ir_d [QDEPTH];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    logic [15:0]    pc_out_q, pc_out_d;
    logic [15:0]    pcp2_out_q, pcp2_out_d;
    logic [15:0]    ir_out_q, ir_out_d;
    logic           fetch_valid_q, fetch_valid_d;

    logic           rsp_take;
    logic           rsp_push;
    logic           rsp_drop;
    logic           pop;
    logic [NW-1:0]  live;
    logic [NW-1:0]  occ;
    logic           req_valid;
    logic           req_fire;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a redirect arms DRAIN when anything is still in flight
    always_comb begin
        state_d = state_q;
        if (jump) begin
            state_d = (inflight_d != '0) ? S_DRAIN : S_RUN;
        end else if (state_q == S_DRAIN && rsp_drop && discard_q == NW'(1)) begin
            state_d = S_RUN;
        end
    end

    // FSM outputs
    always_comb begin
        drop_stale = (state_q == S_DRAIN);
    end

    // Memory handshake and credit; the slot freed by this cycle's pop counts
    // as free so single-cycle memory sustains one fetch per cycle.
    always_comb begin
        rsp_take   = imem.imem_rsp_valid && (inflight_q != '0);
        rsp_drop   = rsp_take && drop_stale;
        rsp_push   = rsp_take && !drop_stale;
        pop        = !jump && !stall && (count_q != '0);
        live       = inflight_q - discard_q;
        occ        = NW'(count_q) - NW'(pop);
        req_valid  = !reset && ((live + occ) < NW'(QDEPTH)) && (inflight_q != '1);
        req_fire   = req_valid && imem.imem_req_ready;
        inflight_d = inflight_q + NW'(req_fire) - NW'(rsp_take);
    end

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = fetch_pc_q;

    // Fetch address, response-PC tracker and stale-word count
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        discard_d  = discard_q;
        if (jump) begin
            fetch_pc_d = new_pc & 16'hFFFE;
            rsp_pc_d   = new_pc & 16'hFFFE;
            // Everything outstanding after this edge belongs to the old stream.
            discard_d  = inflight_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 16'd2;
            end
            if (rsp_push) begin
                rsp_pc_d = rsp_pc_q + 16'd2;
            end
            if (rsp_drop) begin
                discard_d = discard_q - NW'(1);
            end
        end
    end

    // Prefetch queue: push on live response, pop toward IF/ID, flush on jump
    always_comb begin
        q_pc_d   = q_pc_q;
        q_ir_d   = q_ir_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (jump) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (rsp_push) begin
                q_pc_d[wr_ptr_q] = rsp_pc_q;
                q_ir_d[wr_ptr_q] = imem.imem_rsp_data;
                wr_ptr_d         = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(rsp_push) - CW'(pop);
        end
    end

    // IF/ID-facing output register: squash, hold, pop or bubble
    always_comb begin
        pc_out_d      = pc_out_q;
        pcp2_out_d    = pcp2_out_q;
        ir_out_d      = ir_out_q;
        fetch_valid_d = fetch_valid_q;
        if (jump) begin
            ir_out_d      = NOP_INSN;
            fetch_valid_d = 1'b0;
        end else if (stall) begin
            fetch_valid_d = fetch_valid_q;
        end else if (pop) begin
            pc_out_d      = q_pc_q[rd_ptr_q];
            pcp2_out_d    = q_pc_q[rd_ptr_q] + 16'd2;
            ir_out_d      = q_ir_q[rd_ptr_q];
            fetch_valid_d = 1'b1;
        end else begin
            ir_out_d      = NOP_INSN;
            fetch_valid_d = 1'b0;
        end
    end

    // Datapath registers; reset also forgets responses still in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            inflight_q    <= '0;
            discard_q     <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_pc_q[i] <= '0;
                q_ir_q[i] <= '0;
            end
            pc_out_q      <= '0;
            pcp2_out_q    <= '0;
            ir_out_q      <= NOP_INSN;
            fetch_valid_q <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            inflight_q    <= inflight_d;
            discard_q     <= discard_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            q_pc_q        <= q_pc_d;
            q_ir_q        <= q_ir_d;
            pc_out_q      <= pc_out_d;
            pcp2_out_q    <= pcp2_out_d;
            ir_out_q      <= ir_out_d;
            fetch_valid_q <= fetch_valid_d;
        end
    end

    assign pc_out      = pc_out_q;
    assign pcp2_out    = pcp2_out_q;
    assign ir_out      = ir_out_q;
    assign fetch_valid = fetch_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a latency-programmable in-order memory, a stream
// model of the expected IF/ID outputs checked every cycle, and directed
// scenarios with hand-computed expectations.
module tb_fetch_stage;

    localparam logic [15:0] NOP = 16'h0000;
    localparam logic [15:0] RPC = 16'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        jump;
    logic [15:0] new_pc;
    logic [15:0] pc_out;
    logic [15:0] pcp2_out;
    logic [15:0] ir_out;
    logic        fetch_valid;

    fetch_stage_if mif ();

    fetch_stage #(
        .RESET_PC (RPC),
        .NOP_INSN (NOP),
        .QDEPTH   (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .jump        (jump),
        .new_pc      (new_pc),
        .imem        (mif),
        .pc_out      (pc_out),
        .pcp2_out    (pcp2_out),
        .ir_out      (ir_out),
        .fetch_valid (fetch_valid)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    function automatic logic [63:0] pk(input logic [15:0] p, input logic [15:0] p2,
                                       input logic [15:0] ir, input logic v);
        return {p, p2, ir, 15'd0, v};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic logic [63:0] outs();
        return pk(pc_out, pcp2_out, ir_out, fetch_valid);
    endfunction

    // ---------------- memory model ----------------
    typedef struct packed {
        logic [15:0] addr;
        int          due;
    } req_t;

    req_t        pend[$];
    int          cyc = 0;
    int          mem_lat = 1;
    bit          fired_now = 1'b0;
    bit          saw_wrap = 1'b0;
    bit          have_last = 1'b0;
    logic [15:0] last_req_addr = 16'h0;

    initial begin
        mif.imem_rsp_valid = 1'b0;
        mif.imem_rsp_data  = 16'h0;
        forever begin
            bit          f;
            logic [15:0] a;
            @(negedge clk);
            f = mif.imem_req_valid && mif.imem_req_ready;
            a = mif.imem_req_addr;
            @(posedge clk);
            cyc++;
            #1;
            fired_now = f;
            if (f) begin
                if (have_last && last_req_addr == 16'hFFFE && a == 16'h0000) saw_wrap = 1'b1;
                last_req_addr = a;
                have_last     = 1'b1;
                pend.push_back('{addr: a, due: cyc + mem_lat});
            end
            if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
                mif.imem_rsp_valid = 1'b1;
                mif.imem_rsp_data  = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                mif.imem_rsp_valid = 1'b0;
                mif.imem_rsp_data  = 16'hDEAD;
            end
        end
    end

    // ---------------- stream model + per-cycle compare ----------------
    bit          started = 1'b0;
    bit          l_rst, l_jmp, l_stl;
    logic [15:0] l_np;
    logic [15:0] m_pc, m_pcp2, m_ir, exp_pc;
    logic        m_fv;

    initial begin
        m_pc = 16'h0; m_pcp2 = 16'h0; m_ir = NOP; m_fv = 1'b0; exp_pc = RPC;
        forever begin
            logic [15:0] e2;
            @(negedge clk);
            if (started) begin
                if (l_rst) begin
                    check("model_reset", outs(), pk(16'h0, 16'h0, NOP, 1'b0));
                    m_pc = 16'h0; m_pcp2 = 16'h0; m_ir = NOP; m_fv = 1'b0;
                    exp_pc = RPC;
                end else if (l_jmp) begin
                    check("model_jump", outs(), pk(m_pc, m_pcp2, NOP, 1'b0));
                    m_ir = NOP; m_fv = 1'b0;
                    exp_pc = l_np & 16'hFFFE;
                end else if (l_stl) begin
                    check("model_stall", outs(), pk(m_pc, m_pcp2, m_ir, m_fv));
                end else if (fetch_valid) begin
                    e2 = exp_pc + 16'd2;
                    check("model_stream", outs(), pk(exp_pc, e2, mem_word(exp_pc), 1'b1));
                    m_pc = exp_pc; m_pcp2 = e2; m_ir = mem_word(exp_pc); m_fv = 1'b1;
                    exp_pc = e2;
                end else begin
                    check("model_bubble", outs(), pk(m_pc, m_pcp2, NOP, 1'b0));
                    m_ir = NOP; m_fv = 1'b0;
                end
            end
            if (reset) check("req_valid_in_reset", 64'(mif.imem_req_valid), 64'd0);
            else if (mif.imem_req_valid) check("req_addr_even", 64'(mif.imem_req_addr[0]), 64'd0);
            l_rst   = reset;
            l_jmp   = jump;
            l_stl   = stall;
            l_np    = new_pc;
            started = 1'b1;
        end
    end

    task automatic wait_valid(input string name, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            tick(1);
            if (fetch_valid) break;
        end
        check(name, 64'(fetch_valid), 64'd1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        reset = 1'b1; stall = 1'b0; jump = 1'b0; new_pc = 16'h0;
        mif.imem_req_ready = 1'b1;

        tick(2);
        check("reset_state", outs(), pk(16'h0, 16'h0, NOP, 1'b0));
        check("reset_req_valid", 64'(mif.imem_req_valid), 64'd0);
        reset = 1'b0;

        // 1-cycle memory: first instruction lands on the third edge
        tick(2);
        check("lat_edge2", 64'(fetch_valid), 64'd0);
        tick(1);
        check("first_insn", outs(), pk(16'h0000, 16'h0002, 16'hA5A5, 1'b1));
        tick(3);
        check("pc_6", outs(), pk(16'h0006, 16'h0008, 16'hA5A3, 1'b1));

        // stall three edges with pc_out = 6
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("stall_hold", outs(), pk(16'h0006, 16'h0008, 16'hA5A3, 1'b1));
            if (i < 2) check("stall_credit", 64'(mif.imem_req_valid), 64'd0);
        end
        stall = 1'b0;
        tick(1);
        check("stall_resume", outs(), pk(16'h0008, 16'h000A, 16'hA5AD, 1'b1));
        tick(1);
        check("stall_next", outs(), pk(16'h000A, 16'h000C, 16'hA5AF, 1'b1));

        // 3-cycle memory, redirect with two requests outstanding
        mem_lat = 3;
        for (int i = 0; i < 20 && pend.size() != 2; i++) tick(1);
        check("two_outstanding", 64'(pend.size()), 64'd2);
        jump = 1'b1; new_pc = 16'h0041;
        tick(1);
        jump = 1'b0;
        check("jump_squash", {48'd0, ir_out, 15'd0, fetch_valid}, {48'd0, NOP, 16'd0});
        wait_valid("jump_wait", 20);
        check("jump_target", outs(), pk(16'h0040, 16'h0042, 16'hA5E5, 1'b1));

        // redirect again while the first redirect is still draining
        jump = 1'b1; new_pc = 16'h0080;
        tick(1);
        jump = 1'b0;
        tick(1);
        jump = 1'b1; new_pc = 16'h0091;
        tick(1);
        jump = 1'b0;
        wait_valid("rejump_wait", 30);
        check("rejump_target", outs(), pk(16'h0090, 16'h0092, 16'hA535, 1'b1));

        // jump together with stall: squash wins
        stall = 1'b1; jump = 1'b1; new_pc = 16'h0100;
        tick(1);
        jump = 1'b0;
        check("jump_stall_squash", {48'd0, ir_out, 15'd0, fetch_valid}, {48'd0, NOP, 16'd0});
        stall = 1'b0;
        wait_valid("jump_stall_wait", 30);
        check("jump_stall_target", outs(), pk(16'h0100, 16'h0102, 16'hA4A5, 1'b1));

        // address wrap with 1-cycle memory
        mif.imem_req_ready = 1'b0;
        for (int i = 0; i < 20 && pend.size() != 0; i++) tick(1);
        check("mem_drained", 64'(pend.size()), 64'd0);
        mem_lat = 1;
        mif.imem_req_ready = 1'b1;
        jump = 1'b1; new_pc = 16'hFFFC;
        tick(1);
        jump = 1'b0;
        wait_valid("wrap_wait", 20);
        check("wrap_fffc", outs(), pk(16'hFFFC, 16'hFFFE, 16'h5A59, 1'b1));
        tick(1);
        check("wrap_pcp2", outs(), pk(16'hFFFE, 16'h0000, 16'h5A5B, 1'b1));
        tick(1);
        check("wrap_pc", outs(), pk(16'h0000, 16'h0002, 16'hA5A5, 1'b1));
        check("req_addr_wrap", 64'(saw_wrap), 64'd1);

        // reset with requests in flight; a stale word lands after reset
        mem_lat = 3;
        stall = 1'b1; jump = 1'b1; new_pc = 16'h0300;
        tick(1);
        jump = 1'b0;
        for (int i = 0; i < 30 && !(fired_now && pend.size() >= 2); i++) tick(1);
        check("reset_inflight_setup", 64'(fired_now && pend.size() >= 2), 64'd1);
        reset = 1'b1;
        tick(1);
        check("reset_flush", outs(), pk(16'h0, 16'h0, NOP, 1'b0));
        check("reset_flush_req", 64'(mif.imem_req_valid), 64'd0);
        tick(1);
        reset = 1'b0;
        stall = 1'b0;
        wait_valid("post_reset_wait", 30);
        check("post_reset_first", outs(), pk(RPC, 16'h0002, 16'hA5A5, 1'b1));
        tick(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule
